// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave exposing an internal 16-bit word RAM through READ (8'h03) and WRITE (8'h02).
// Serial pins are oversampled by clk; sclk is only ever treated as data, never as a clock.
module spi_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csb_i,
    input  logic              sclk_i,
    input  logic              si_i,
    output logic              so_o,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [15:0]       load_data_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_e;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_FF-1:0] csb_sync_q;
    logic [SYNC_FF-1:0] sclk_sync_q;
    logic [SYNC_FF-1:0] si_sync_q;
    logic               csb_prev_q;
    logic               sclk_prev_q;

    // NOTE: synchroniser flops carry no reset so that a reset pulse in the middle of a
    // frame cannot fabricate a csb edge; they simply track the pins every cycle.
    always_ff @(posedge clk) begin
        csb_sync_q  <= {csb_sync_q[SYNC_FF-2:0], csb_i};
        sclk_sync_q <= {sclk_sync_q[SYNC_FF-2:0], sclk_i};
        si_sync_q   <= {si_sync_q[SYNC_FF-2:0], si_i};
        csb_prev_q  <= csb_sync_q[SYNC_FF-1];
        sclk_prev_q <= sclk_sync_q[SYNC_FF-1];
    end

    logic csb_s;
    logic sclk_s;
    logic si_s;
    logic csb_fall;
    logic csb_rise;
    logic sclk_rise;
    logic sclk_fall;
    logic armed_q;

    assign csb_s     = csb_sync_q[SYNC_FF-1];
    assign sclk_s    = sclk_sync_q[SYNC_FF-1];
    assign si_s      = si_sync_q[SYNC_FF-1];
    // A frame may only start once csb has been seen high since the last reset.
    assign csb_fall  = csb_prev_q & ~csb_s & armed_q;
    assign csb_rise  = ~csb_prev_q & csb_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [4:0]        bit_cnt_q;
    logic [15:0]       shift_q;
    logic [15:0]       shift_d;
    logic [ADDR_W-1:0] word_addr_q;
    logic [ADDR_W-1:0] word_addr_inc_d;
    logic              rd_op_q;
    logic              wr_op_q;
    logic              fetch_q;
    logic              wr_pend_q;
    logic [15:0]       wr_data_q;
    logic              so_q;
    logic              busy_q;
    logic              err_q;
    logic [15:0]       mem_q [DEPTH];

    assign shift_d         = {shift_q[14:0], si_s};
    assign word_addr_inc_d = word_addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_addr_q <= '0;
            rd_op_q     <= 1'b0;
            wr_op_q     <= 1'b0;
            fetch_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_data_q   <= '0;
            so_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            busy_q <= ~csb_s;
            if (csb_s) begin
                armed_q <= 1'b1;
            end
            // NOTE: one-cycle strobes default low here and are raised below when needed;
            // a later non-blocking assignment in the same block overrides this default.
            fetch_q   <= 1'b0;
            wr_pend_q <= 1'b0;

            if (wr_pend_q) begin
                word_addr_q <= word_addr_inc_d;
            end
            if (fetch_q) begin
                shift_q <= mem_q[word_addr_q];
            end

            if (csb_rise) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                so_q      <= 1'b0;
            end else if (csb_fall) begin
                state_q   <= ST_CMD;
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_ADDR;
                                rd_op_q   <= (shift_d[7:0] == OP_READ);
                                wr_op_q   <= (shift_d[7:0] == OP_WRITE);
                                if (shift_d[7:0] != OP_READ && shift_d[7:0] != OP_WRITE) begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd15) begin
                                // Byte address in, word index out: bit 0 and high bits dropped.
                                bit_cnt_q   <= '0;
                                word_addr_q <= shift_d[ADDR_W:1];
                                if (rd_op_q) begin
                                    state_q <= ST_RD;
                                    fetch_q <= 1'b1;
                                end else if (wr_op_q) begin
                                    state_q <= ST_WR;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_RD: begin
                        if (sclk_fall) begin
                            so_q      <= shift_q[15];
                            shift_q   <= {shift_q[14:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd15) begin
                                bit_cnt_q   <= '0;
                                word_addr_q <= word_addr_inc_d;
                                fetch_q     <= 1'b1;
                            end
                        end
                    end
                    ST_WR: begin
                        if (sclk_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd15) begin
                                bit_cnt_q <= '0;
                                wr_data_q <= shift_d;
                                wr_pend_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Word RAM: SPI write has priority; backdoor load only while idle
    // ------------------------------------------------------------------
    // NOTE: the RAM array is deliberately not reset; contents survive reset and it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            mem_q[word_addr_q] <= wr_data_q;
        end else if (load_en_i && !busy_q) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    assign so_o   = so_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomised SPI master driving spi_mem_responder, checked against a plain word-array memory model.
module tb_spi_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int H      = 5;

    logic              clk;
    logic              reset;
    logic              csb_i;
    logic              sclk_i;
    logic              si_i;
    logic              so_o;
    logic              load_en_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [15:0]       load_data_i;
    logic              busy_o;
    logic              err_o;

    spi_mem_responder #(.ADDR_W(ADDR_W), .SYNC_FF(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .csb_i       (csb_i),
        .sclk_i      (sclk_i),
        .si_i        (si_i),
        .so_o        (so_o),
        .load_en_i   (load_en_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ref_mem [DEPTH];
    int          n_cmp;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int word_of(input logic [15:0] byte_addr);
        return int'(byte_addr / 2) % DEPTH;
    endfunction

    // One mode-0 bit: drive si in the low phase, sample so just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        si_i = b;
        wait_clk(H);
        r = so_o;
        sclk_i = 1'b1;
        wait_clk(H);
        sclk_i = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] rx);
        logic r;
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], r);
            rx = {rx[30:0], r};
        end
    endtask

    task automatic csb_down();
        @(negedge clk);
        csb_i = 1'b0;
        wait_clk(H);
    endtask

    task automatic csb_up();
        wait_clk(H);
        csb_i = 1'b1;
        si_i  = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic do_load(input int w, input logic [15:0] d);
        load_en_i   = 1'b1;
        load_addr_i = ADDR_W'(w);
        load_data_i = d;
        @(negedge clk);
        load_en_i = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic do_read(input logic [15:0] addr, input int nwords, input string tag);
        logic [31:0] rx;
        int          w;
        w = word_of(addr);
        csb_down();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'(addr), 16, rx);
        for (int k = 0; k < nwords; k++) begin
            spi_bits(32'h0, 16, rx);
            check(tag, rx, 32'(ref_mem[w]));
            w = (w + 1) % DEPTH;
        end
        csb_up();
    endtask

    // Full words update the model; trailing partial bits must be discarded by the DUT.
    task automatic do_write(input logic [15:0] addr, input int nwords, input int extra,
                            input logic [15:0] first);
        logic [31:0] rx;
        logic [15:0] d;
        int          w;
        w = word_of(addr);
        csb_down();
        spi_bits(32'h02, 8, rx);
        spi_bits(32'(addr), 16, rx);
        for (int k = 0; k < nwords; k++) begin
            d = (k == 0) ? first : 16'($urandom);
            spi_bits(32'(d), 16, rx);
            ref_mem[w] = d;
            w = (w + 1) % DEPTH;
        end
        if (extra > 0) begin
            spi_bits($urandom, extra, rx);
        end
        csb_up();
    endtask

    // Unsupported opcode frame; also tries a backdoor load while busy, which must be dropped.
    task automatic do_bad(input logic [7:0] op, input int load_w, input string tag);
        logic [31:0] rx;
        logic [31:0] seen;
        csb_down();
        spi_bits(32'(op), 8, rx);
        seen = rx;
        load_en_i   = 1'b1;
        load_addr_i = ADDR_W'(load_w);
        load_data_i = ~ref_mem[load_w];
        @(negedge clk);
        load_en_i = 1'b0;
        spi_bits($urandom, 16, rx);
        seen = seen | rx;
        spi_bits($urandom, 16, rx);
        seen = seen | rx;
        check({tag, "_so"}, seen, 32'h0);
        csb_up();
        check({tag, "_err"}, 32'(err_o), 32'h1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [7:0]  op;
        int          kind;

        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        csb_i       = 1'b1;
        sclk_i      = 1'b0;
        si_i        = 1'b0;
        load_en_i   = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(2);
        check("rst_so", 32'(so_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            do_load(i, 16'($urandom));
        end
        do_load(5, 16'hBEEF);
        do_read(16'h000A, 1, "beef");

        do_write(16'h0004, 1, 0, 16'h1234);
        do_read(16'h0004, 1, "wr1234");
        do_read(16'h0002, 1, "word1_kept");

        do_read(16'(2 * (DEPTH - 1)), 2, "wrap");

        csb_down();
        spi_bits(32'h02, 8, rx);
        spi_bits(32'h0000, 16, rx);
        spi_bits(32'h1FF, 9, rx);
        check("partial_busy1", 32'(busy_o), 32'h1);
        csb_up();
        check("partial_busy0", 32'(busy_o), 32'h0);
        do_read(16'h0000, 1, "partial_kept");

        do_bad(8'h05, 7, "bad05");
        do_read(16'h000E, 1, "load_dropped");
        check("err_cleared", 32'(err_o), 32'h0);

        csb_down();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'h00, 8, rx);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        spi_bits(32'h0A, 8, rx);
        spi_bits(32'h0, 16, rx);
        check("rst_mid_so", rx, 32'h0);
        check("rst_mid_err", 32'(err_o), 32'h0);
        csb_up();
        do_read(16'h000A, 1, "after_rst");

        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: do_read(16'($urandom), $urandom_range(1, 3), "rnd_rd");
                2: do_write(16'($urandom), $urandom_range(1, 2),
                            ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0,
                            16'($urandom));
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h02 || op == 8'h03) op = 8'hFF;
                    do_bad(op, $urandom_range(0, DEPTH - 1), "rnd_bad");
                end
            endcase
        end
        do_read(16'h0000, 3, "final_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
